ts_scroller: RTL

Text-memory scroll/clear sequencer for the text subsystem. When the cursor unit reports a scroll, or the command decoder requests a screen clear, the block takes ownership of the text RAM. It streams every cell up by one or two rows (one cell per cycle), fills the vacated bottom rows with a blank cell, and holds `busy` so the character writer and cursor stall until the memory is consistent again.

---
 rtl/ts_scroller_pkg.sv | 5 +
 rtl/ts_scroller.sv | 84 ++++++++
 2 files changed

// File: rtl/ts_scroller_pkg.sv
// ts_scroller_pkg: shared address width and sequencer state encoding for the text scroller
package ts_scroller_pkg;
    localparam int ADDR_W = 12;
    typedef enum logic [1:0] {S_IDLE, S_COPY, S_CLEAR, S_DONE} state_t;
endpackage

// File: rtl/ts_scroller.sv
// ts_scroller: text-RAM scroll/clear sequencer (moves cells up 1-2 rows, blanks vacated rows)
// Ports: clk, reset (sync, active-high); scroll/lines/clear requests; busy, done status;
//        rd_en/rd_addr/rd_data RAM read port (1-cycle latency); wr_en/wr_addr/wr_data RAM write port.
module ts_scroller
    import ts_scroller_pkg::*;
#(
    parameter logic [6:0]            COLUMNS    = 7'd80,
    parameter logic [5:0]            ROWS       = 6'd51,
    parameter int                    CELL_WIDTH = 32,
    parameter logic [CELL_WIDTH-1:0] CLEAR_CELL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scroll,
    input  logic [1:0]            lines,
    input  logic                  clear,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [CELL_WIDTH-1:0] rd_data,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [CELL_WIDTH-1:0] wr_data
);
    localparam logic [ADDR_W-1:0] COLS  = ADDR_W'(COLUMNS);
    localparam logic [ADDR_W-1:0] NROWS = ADDR_W'(ROWS);
    localparam logic [ADDR_W-1:0] CELLS = NROWS * COLS;
    localparam logic [ADDR_W-1:0] LAST  = CELLS - 1'b1;

    state_t              state, next;
    logic                two;
    logic [ADDR_W-1:0]   rp, wp, pa, off;
    logic                pv;

    assign off = two ? COLS << 1 : COLS;

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  next = clear ? S_CLEAR : scroll ? S_COPY : S_IDLE;
            S_COPY:  next = (rp == LAST) ? S_CLEAR : S_COPY;
            S_CLEAR: next = (!pv && wp == LAST) ? S_DONE : S_CLEAR;
            default: next = S_IDLE;
        endcase
    end

    // A pending copy write (pv) takes priority over clear writes, which gives the
    // scroll path its one-cycle CLEAR setup slot without any bubble in the writes.
    always_comb begin
        busy    = state == S_COPY || state == S_CLEAR;
        done    = state == S_DONE;
        rd_en   = state == S_COPY;
        rd_addr = rd_en ? rp : '0;
        wr_en   = pv || state == S_CLEAR;
        wr_addr = pv ? pa : (state == S_CLEAR ? wp : '0);
        wr_data = pv ? rd_data : (state == S_CLEAR ? CLEAR_CELL : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            two   <= 1'b0;
            rp    <= '0;
            wp    <= '0;
            pa    <= '0;
            pv    <= 1'b0;
        end else begin
            state <= next;
            pv    <= state == S_COPY;
            pa    <= rp - off;
            if (state == S_IDLE) begin
                two <= lines >= 2'd2;
                rp  <= (lines >= 2'd2) ? COLS << 1 : COLS;
                wp  <= '0;
            end
            if (state == S_COPY) begin
                rp <= rp + 1'b1;
                if (rp == LAST) wp <= CELLS - off;
            end
            if (state == S_CLEAR && !pv) wp <= wp + 1'b1;
        end
    end
endmodule
